// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches under a credit rule and buffers
// {pc, inst} pairs for decode; redirects flush the queue and restart fetch.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_en,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic [XLEN-1:0]          out_pc_plus_4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            in_flight;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] redirect_addr;
  logic [CW:0]     credit_used;
  logic            push;
  logic            pop;

  // An outstanding request already owns a slot, so it counts against free space.
  assign redirect_addr = {redirect_pc[XLEN-1:2], 2'b00};
  assign credit_used   = {1'b0, count} + {{CW{1'b0}}, in_flight};
  assign imem_en       = rst & (redirect_valid | (credit_used < (CW+1)'(DEPTH)));
  assign imem_addr     = redirect_valid ? redirect_addr : {fetch_pc[XLEN-1:2], 2'b00};

  assign push          = in_flight & ~redirect_valid;
  assign out_valid     = (count != '0) & ~redirect_valid;
  assign pop           = out_valid & out_ready;

  assign out_pc        = pc_mem[rd_ptr];
  assign out_inst      = inst_mem[rd_ptr];
  assign out_pc_plus_4 = out_pc + XLEN'(4);
  assign occupancy     = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= RESET_PC;
      in_flight <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      in_flight <= imem_en;
      if (imem_en) begin
        req_pc   <= imem_addr;
        fetch_pc <= imem_addr + XLEN'(4);
      end
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (!push && pop)
          count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset; an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a one-cycle memory model answers fetches and a
// scoreboard of expected PCs is compared against every delivered head entry.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_en, imem_en_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic [31:0] imem_data, imem_data_w;
  logic        redirect_valid, redirect_valid_w;
  logic [31:0] redirect_pc, redirect_pc_w;
  logic        out_valid, out_valid_w;
  logic        out_ready, out_ready_w;
  logic [31:0] out_pc, out_pc_w;
  logic [31:0] out_inst, out_inst_w;
  logic [31:0] out_pc_plus_4, out_pc_plus_4_w;
  logic [2:0]  occupancy, occupancy_w;

  int          total;
  int          bad;
  logic [31:0] sb [$];
  logic        mem_en, mem_en_w;
  logic [31:0] mem_addr, mem_addr_w;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_pc_plus_4(out_pc_plus_4),
    .occupancy(occupancy)
  );

  // Second instance starts near the top of the address space to exercise wrap.
  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .imem_en(imem_en_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_pc(out_pc_w), .out_inst(out_inst_w), .out_pc_plus_4(out_pc_plus_4_w),
    .occupancy(occupancy_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic checkDelivery(input string tag);
    logic [31:0] e;
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_pc"},   64'(out_pc),        64'(e));
      checkOutput({tag, "_inst"}, 64'(out_inst),      64'(inst_of(e)));
      checkOutput({tag, "_pc4"},  64'(out_pc_plus_4), 64'(e + 32'd4));
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic ready);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ready;
  endtask

  // Memory answers in the cycle after the request; returns at posedge + 1.
  task automatic tick();
    @(negedge clk);
    mem_en     = imem_en;
    mem_addr   = imem_addr;
    mem_en_w   = imem_en_w;
    mem_addr_w = imem_addr_w;
    @(posedge clk);
    #1;
    imem_data   = mem_en   ? inst_of(mem_addr)   : 32'hBAD0_0000;
    imem_data_w = mem_en_w ? inst_of(mem_addr_w) : 32'hBAD0_0000;
  endtask

  task automatic resetDut(input logic ready);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, ready);
    sb.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    redirect_valid_w = 1'b0;
    redirect_pc_w    = 32'h0;
    out_ready_w      = 1'b1;
    imem_data        = 32'h0;
    imem_data_w      = 32'h0;

    #1 rst = 1'b0;
    #1;
    checkOutput("rst_en",    64'(imem_en),   64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_occ",   64'(occupancy), 64'd0);
    checkOutput("rst_en_w",  64'(imem_en_w), 64'd0);
    tick();
    tick();

    // Cold start plus wrap instance running alongside.
    rst = 1'b1;
    #1;
    checkOutput("cold_en0",    64'(imem_en),     64'd1);
    checkOutput("cold_addr0",  64'(imem_addr),   64'h0);
    checkOutput("cold_valid0", 64'(out_valid),   64'd0);
    checkOutput("wrap_addr0",  64'(imem_addr_w), 64'hFFFF_FFF8);
    sb.push_back(32'h0);
    tick();
    #1;
    checkOutput("cold_addr1",  64'(imem_addr),   64'h4);
    checkOutput("cold_valid1", 64'(out_valid),   64'd0);
    checkOutput("wrap_addr1",  64'(imem_addr_w), 64'hFFFF_FFFC);
    sb.push_back(32'h4);
    tick();
    for (int i = 2; i < 8; i++) begin
      #1;
      checkOutput("cold_addr", 64'(imem_addr), 64'(32'(4 * i)));
      sb.push_back(32'(4 * i));
      checkDelivery("cold");
      checkOutput("cold_occ", 64'(occupancy), 64'd1);
      if (i == 2) begin
        checkOutput("wrap_addr2", 64'(imem_addr_w), 64'h0);
        checkOutput("wrap_pc2",   64'(out_pc_w),    64'hFFFF_FFF8);
      end
      if (i == 3) begin
        checkOutput("wrap_pc3",  64'(out_pc_w),        64'hFFFF_FFFC);
        checkOutput("wrap_pc4",  64'(out_pc_plus_4_w), 64'h0);
      end
      if (i >= 3) checkOutput("wrap_occ", 64'(occupancy_w), 64'd1);
      tick();
    end

    // Back-pressure from reset: queue fills to 4, then drains in order.
    resetDut(1'b0);
    #1;
    checkOutput("bp_addr0", 64'(imem_addr), 64'h0);
    sb.push_back(32'h0);
    tick();
    #1;
    checkOutput("bp_addr1", 64'(imem_addr), 64'h4);
    sb.push_back(32'h4);
    tick();
    #1;
    checkOutput("bp_occ2",  64'(occupancy), 64'd1);
    checkOutput("bp_addr2", 64'(imem_addr), 64'h8);
    sb.push_back(32'h8);
    tick();
    #1;
    checkOutput("bp_occ3",  64'(occupancy), 64'd2);
    checkOutput("bp_addr3", 64'(imem_addr), 64'hC);
    sb.push_back(32'hC);
    tick();
    #1;
    checkOutput("bp_occ4", 64'(occupancy), 64'd3);
    checkOutput("bp_en4",  64'(imem_en),   64'd0);
    tick();
    #1;
    checkOutput("bp_occ5",  64'(occupancy), 64'd4);
    checkOutput("bp_en5",   64'(imem_en),   64'd0);
    checkOutput("bp_head5", 64'(out_pc),    64'h0);
    tick();
    #1;
    checkOutput("bp_occ6", 64'(occupancy), 64'd4);
    checkOutput("bp_en6",  64'(imem_en),   64'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    sb.push_back(32'h10);
    sb.push_back(32'h14);
    #1;
    checkOutput("bp_en7", 64'(imem_en), 64'd0);
    checkDelivery("drain");
    tick();
    #1;
    checkOutput("bp_en8",   64'(imem_en),   64'd1);
    checkOutput("bp_addr8", 64'(imem_addr), 64'h10);
    checkDelivery("drain");
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checkDelivery("drain");
      tick();
    end

    // Redirect with three queued entries and one fetch in flight.
    resetDut(1'b0);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(1'b1, 32'h100, 1'b1);
    #1;
    checkOutput("rd_occ_pre", 64'(occupancy), 64'd3);
    checkOutput("rd_en",      64'(imem_en),   64'd1);
    checkOutput("rd_addr",    64'(imem_addr), 64'h100);
    checkOutput("rd_valid",   64'(out_valid), 64'd0);
    sb.delete();
    sb.push_back(32'h100);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("rd_occ_post", 64'(occupancy), 64'd0);
    checkOutput("rd_valid1",   64'(out_valid), 64'd0);
    checkOutput("rd_addr1",    64'(imem_addr), 64'h104);
    sb.push_back(32'h104);
    tick();
    #1;
    checkDelivery("redir");
    checkOutput("rd_addr2", 64'(imem_addr), 64'h108);
    sb.push_back(32'h108);
    tick();
    #1;
    checkDelivery("redir");
    tick();
    #1;
    checkDelivery("redir");
    tick();

    // Back-to-back redirects, the first one misaligned; the second wins.
    applyStimulus(1'b1, 32'h203, 1'b1);
    #1;
    checkOutput("b2b_addr0",  64'(imem_addr), 64'h200);
    checkOutput("b2b_valid0", 64'(out_valid), 64'd0);
    sb.delete();
    tick();
    applyStimulus(1'b1, 32'h300, 1'b1);
    #1;
    checkOutput("b2b_addr1",  64'(imem_addr), 64'h300);
    checkOutput("b2b_valid1", 64'(out_valid), 64'd0);
    checkOutput("b2b_occ1",   64'(occupancy), 64'd0);
    sb.push_back(32'h300);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("b2b_occ2",   64'(occupancy), 64'd0);
    checkOutput("b2b_valid2", 64'(out_valid), 64'd0);
    checkOutput("b2b_addr2",  64'(imem_addr), 64'h304);
    sb.push_back(32'h304);
    tick();
    #1;
    checkDelivery("b2b");
    tick();
    #1;
    checkDelivery("b2b");
    tick();

    // Asynchronous reset between edges with two entries queued.
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("ar_occ1", 64'(occupancy), 64'd1);
    tick();
    #1;
    checkOutput("ar_occ2",   64'(occupancy), 64'd2);
    checkOutput("ar_valid2", 64'(out_valid), 64'd1);
    checkOutput("ar_en2",    64'(imem_en),   64'd1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("ar_valid_rst", 64'(out_valid), 64'd0);
    checkOutput("ar_en_rst",    64'(imem_en),   64'd0);
    checkOutput("ar_occ_rst",   64'(occupancy), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    sb.delete();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("ar_en_rel",    64'(imem_en),   64'd1);
    checkOutput("ar_addr_rel",  64'(imem_addr), 64'h0);
    checkOutput("ar_valid_rel", 64'(out_valid), 64'd0);
    sb.push_back(32'h0);
    tick();
    #1;
    checkOutput("ar_addr1", 64'(imem_addr), 64'h4);
    sb.push_back(32'h4);
    tick();
    #1;
    checkDelivery("restart");
    tick();
    #1;
    checkDelivery("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
